// File: rtl/compute_score.sv
// Pipelined chaining-score kernel: result = alpha - beta for an anchor pair.
// Four registered stages; one operand set accepted every clock, no handshake.
// Stream contract: there is no valid/ready pair; every clock the inputs are
// sampled and the score for them appears on result after the fourth rising
// edge (counting the sampling edge). Reset flushes everything in flight.
module compute_score #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] riX,
  input  logic [31:0] riY,
  input  logic [31:0] qiX,
  input  logic [31:0] qiY,
  input  logic [31:0] W,
  input  logic [31:0] W_avg,
  output logic [31:0] result
);

  // floor(n/100) == ((n >> 2) * ceil(2^66/25)) >> 66 for any 64-bit n.
  localparam logic [63:0]        RECIP    = 64'h28F5_C28F_5C28_F5C3;
  localparam logic [30:0]        SAT31    = 31'h7FFF_FFFF;
  localparam logic signed [33:0] POS_MAX  = 34'sd2147483647;
  localparam logic signed [33:0] NEG_MIN  = -34'sd2147483647;
  localparam logic [31:0]        SENTINEL = 32'h8000_0000;

  // Stage 1 registers
  logic [31:0] dr_q, dr_d;
  logic [31:0] dq_q, dq_d;
  logic        inv1_q, inv1_d;
  logic [31:0] w1_q, w1_d;
  logic [31:0] wavg1_q, wavg1_d;
  // Stage 2 registers
  logic        inv2_q, inv2_d;
  logic [31:0] alpha2_q, alpha2_d;
  logic [3:0]  lg2_q, lg2_d;
  logic        ddz2_q, ddz2_d;
  logic [63:0] prod2_q, prod2_d;
  // Stage 3 registers
  logic        inv3_q, inv3_d;
  logic [31:0] alpha3_q, alpha3_d;
  logic [30:0] beta3_q, beta3_d;
  // Stage 4 register (the output)
  logic [31:0] result_q, result_d;

  // Stage 1 helpers
  logic [32:0] dr_full;
  logic [32:0] dq_full;
  // Stage 2 helpers
  logic [31:0] dd;
  logic [31:0] gap;
  logic [4:0]  log2_dd;
  // Stage 3 helpers
  logic [125:0] recip_mul;
  logic [59:0]  lin_full;
  logic [30:0]  lin;
  logic [31:0]  beta_sum;
  // Stage 4 helpers
  logic signed [33:0] diff;

  // Stage 1: 33-bit signed deltas and the invalid-pair flag; dr and dq are
  // only ever used downstream when both are positive, so 32 bits suffice.
  always_comb begin
    dr_full = {1'b0, riX} - {1'b0, riY};
    dq_full = {1'b0, qiX} - {1'b0, qiY};
    inv1_d  = dr_full[32] | (dr_full == 33'd0) | dq_full[32] | (dq_full == 33'd0);
    dr_d    = dr_full[31:0];
    dq_d    = dq_full[31:0];
    w1_d    = W;
    wavg1_d = W_avg;
  end

  // Stage 2: diagonal drift, capped gap reward, leading-one log and product.
  always_comb begin
    dd       = (dr_q >= dq_q) ? (dr_q - dq_q) : (dq_q - dr_q);
    gap      = (dr_q <= dq_q) ? dr_q : dq_q;
    alpha2_d = (gap <= w1_q) ? gap : w1_q;
    log2_dd  = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (dd[i]) log2_dd = 5'(i);
    end
    lg2_d    = log2_dd[4:1];
    ddz2_d   = (dd == 32'd0);
    prod2_d  = {32'd0, dd} * {32'd0, wavg1_q};
    inv2_d   = inv1_q;
  end

  // Stage 3: exact divide-by-100 through a reciprocal multiply, then beta.
  always_comb begin
    recip_mul = {64'd0, prod2_q[63:2]} * {62'd0, RECIP};
    lin_full  = recip_mul[125:66];
    lin       = (lin_full > 60'({SAT31})) ? SAT31 : lin_full[30:0];
    beta_sum  = {1'b0, lin} + {28'd0, lg2_q};
    if (ddz2_q)
      beta3_d = 31'd0;
    else if (beta_sum > {1'b0, SAT31})
      beta3_d = SAT31;
    else
      beta3_d = beta_sum[30:0];
    alpha3_d  = alpha2_q;
    inv3_d    = inv2_q;
  end

  // Stage 4: signed subtract, symmetric saturation, sentinel override.
  always_comb begin
    diff = $signed({2'b00, alpha3_q}) - $signed({3'b000, beta3_q});
    if (inv3_q)
      result_d = SENTINEL;
    else if (diff > POS_MAX)
      result_d = 32'h7FFF_FFFF;
    else if (diff < NEG_MIN)
      result_d = 32'h8000_0001;
    else
      result_d = diff[31:0];
  end

  // All pipeline state; asynchronous active-low clear flushes in-flight work.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dr_q     <= '0;
      dq_q     <= '0;
      inv1_q   <= 1'b0;
      w1_q     <= '0;
      wavg1_q  <= '0;
      inv2_q   <= 1'b0;
      alpha2_q <= '0;
      lg2_q    <= '0;
      ddz2_q   <= 1'b0;
      prod2_q  <= '0;
      inv3_q   <= 1'b0;
      alpha3_q <= '0;
      beta3_q  <= '0;
      result_q <= '0;
    end else begin
      dr_q     <= dr_d;
      dq_q     <= dq_d;
      inv1_q   <= inv1_d;
      w1_q     <= w1_d;
      wavg1_q  <= wavg1_d;
      inv2_q   <= inv2_d;
      alpha2_q <= alpha2_d;
      lg2_q    <= lg2_d;
      ddz2_q   <= ddz2_d;
      prod2_q  <= prod2_d;
      inv3_q   <= inv3_d;
      alpha3_q <= alpha3_d;
      beta3_q  <= beta3_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

  // Low reciprocal-product bits and the two product LSBs do not affect the
  // quotient; LATENCY is descriptive only.
  logic unused_bits;
  assign unused_bits = ^{recip_mul[65:0], prod2_q[1:0], 32'(LATENCY)};

endmodule

// File: tb/tb_compute_score.sv
// Self-checking bench for compute_score: directed vectors from the scoring
// rules, reset behaviour, then a randomized stream against a reference model.
module tb_compute_score;

  logic        clk;
  logic        reset;
  logic [31:0] riX, riY, qiX, qiY, W, W_avg;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  compute_score #(.LATENCY(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .riX    (riX),
    .riY    (riY),
    .qiX    (qiX),
    .qiY    (qiY),
    .W      (W),
    .W_avg  (W_avg),
    .result (result)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the scoring rules in plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [31:0] rx, input logic [31:0] ry,
                                        input logic [31:0] qx, input logic [31:0] qy,
                                        input logic [31:0] w, input logic [31:0] wa);
    longint dr, dq, dd, gap, alpha, lin, lg, t, beta, res;
    logic [63:0] prod;
    dr = longint'(rx) - longint'(ry);
    dq = longint'(qx) - longint'(qy);
    if (dr <= 0 || dq <= 0) return 32'h8000_0000;
    dd    = (dr > dq) ? dr - dq : dq - dr;
    gap   = (dr < dq) ? dr : dq;
    alpha = (gap < longint'(w)) ? gap : longint'(w);
    prod  = 64'(dd) * 64'(wa);
    prod  = prod / 64'd100;
    lin   = (prod > 64'd2147483647) ? 2147483647 : longint'(prod);
    lg = 0;
    t  = dd;
    while (t > 1) begin
      t  = t >> 1;
      lg = lg + 1;
    end
    lg   = lg >> 1;
    beta = (dd == 0) ? 0 : lin + lg;
    if (beta > 2147483647) beta = 2147483647;
    res = alpha - beta;
    if (res > 2147483647) res = 2147483647;
    if (res < -2147483647) res = -2147483647;
    return res[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: result=%h expected=%h", tag, got, exp);
    end
  endtask

  // Driver: called at a negedge; applies one operand set, advances one clock,
  // checks the output due after that edge, returns at the next negedge.
  task automatic drive(input string tag,
                       input logic [31:0] rx, input logic [31:0] ry,
                       input logic [31:0] qx, input logic [31:0] qy,
                       input logic [31:0] w, input logic [31:0] wa,
                       input logic [31:0] exp);
    logic [31:0] due;
    riX = rx; riY = ry; qiX = qx; qiY = qy; W = w; W_avg = wa;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    due = exp_q.pop_front();
    check(tag, result, due);
    @(negedge clk);
  endtask

  // Pipeline is empty after reset: the next three edges yield zero.
  task automatic flush_expect();
    exp_q.delete();
    repeat (3) exp_q.push_back(32'd0);
  endtask

  initial begin
    logic [31:0] rx, ry, qx, qy, w, wa;
    int mode;

    // Reset held with arbitrary inputs: output stays zero.
    reset = 1'b0;
    riX = 32'd100; riY = 32'd30; qiX = 32'd50; qiY = 32'd20; W = 32'd40; W_avg = 32'd40;
    #2;
    check("reset_async", result, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      riX = $urandom; riY = $urandom; qiX = $urandom; qiY = $urandom;
      check("reset_hold", result, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    flush_expect();

    // Nominal vector held: zero for three edges, 12 from the fourth on.
    for (int i = 0; i < 6; i++)
      drive("nominal", 32'd100, 32'd30, 32'd50, 32'd20, 32'd40, 32'd40, 32'd12);

    // Back-to-back: nominal, zero drift, invalid order.
    drive("stream_nominal", 32'd100, 32'd30, 32'd50, 32'd20, 32'd40, 32'd40, 32'd12);
    drive("stream_zero_drift", 32'd200, 32'd100, 32'd150, 32'd50, 32'd40, 32'd40, 32'd40);
    drive("stream_invalid_r", 32'd30, 32'd100, 32'd50, 32'd20, 32'd40, 32'd40, 32'h8000_0000);
    drive("invalid_dq_zero", 32'd100, 32'd30, 32'd20, 32'd20, 32'd40, 32'd40, 32'h8000_0000);
    drive("large_penalty", 32'd1000, 32'd0, 32'd10, 32'd0, 32'd50, 32'd100, 32'hFFFF_FC28);
    drive("neg_saturate", 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'h8000_0002);
    drive("pos_saturate", 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd7,
          32'h7FFF_FFFF);
    drive("dd_one", 32'd10, 32'd0, 32'd9, 32'd0, 32'd100, 32'd250, 32'd7);

    // Mid-stream reset pulse: output clears at once, in-flight work is lost.
    drive("pre_reset_a", 32'd100, 32'd30, 32'd50, 32'd20, 32'd40, 32'd40, 32'd12);
    drive("pre_reset_b", 32'd200, 32'd100, 32'd150, 32'd50, 32'd40, 32'd40, 32'd40);
    reset = 1'b0;
    #1;
    check("mid_reset_now", result, 32'd0);
    @(posedge clk);
    #1;
    check("mid_reset_edge", result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    flush_expect();
    drive("post_reset_0", 32'd1000, 32'd0, 32'd10, 32'd0, 32'd50, 32'd100, 32'hFFFF_FC28);
    drive("post_reset_1", 32'd100, 32'd30, 32'd50, 32'd20, 32'd40, 32'd40, 32'd12);
    drive("post_reset_2", 32'd100, 32'd30, 32'd50, 32'd20, 32'd40, 32'd40, 32'd12);
    drive("post_reset_3", 32'd100, 32'd30, 32'd50, 32'd20, 32'd40, 32'd40, 32'd12);

    // Randomized stream against the reference model.
    for (int i = 0; i < 400; i++) begin
      mode = $urandom_range(0, 3);
      ry = $urandom;
      qy = $urandom;
      case (mode)
        0: begin
          rx = $urandom; qx = $urandom;
          w = $urandom; wa = $urandom;
        end
        1: begin
          rx = ry + $urandom_range(0, 3000);
          qx = qy + $urandom_range(0, 3000);
          w  = $urandom_range(0, 4000);
          wa = $urandom_range(0, 500);
        end
        2: begin
          ry = $urandom_range(0, 1000);
          qy = $urandom_range(0, 1000);
          rx = ry + $urandom;
          qx = qy + $urandom_range(1, 100);
          w  = $urandom;
          wa = $urandom;
        end
        default: begin
          rx = ry + $urandom_range(1, 50);
          qx = qy + $urandom_range(1, 50);
          w  = $urandom_range(0, 60);
          wa = $urandom_range(0, 100000);
        end
      endcase
      drive("random", rx, ry, qx, qy, w, wa, model(rx, ry, qx, qy, w, wa));
    end

    // Drain the last in-flight results.
    for (int i = 0; i < 3; i++)
      drive("drain", 32'd100, 32'd30, 32'd50, 32'd20, 32'd40, 32'd40, 32'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/compute_score.md
Name: compute_score

Overview:
- Pipelined chaining-score kernel for the minimap2 DP chaining accelerator.
- Takes two anchor coordinates (anchor i, predecessor j) plus a max-gap bound W and an average seed weight W_avg.
- Produces the signed integer chaining score alpha − beta (gap reward minus gap-cost penalty).
- Fully pipelined: accepts one new operand set per clock, no handshake.

Parameters:
- LATENCY, 4, clock cycles from input sample to result; fixed at 4 (parameter is informational; other values unsupported).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- riX  input  32  reference position of anchor i (unsigned).
- riY  input  32  reference position of predecessor anchor j (unsigned).
- qiX  input  32  query position of anchor i (unsigned).
- qiY  input  32  query position of predecessor anchor j (unsigned).
- W  input  32  maximum gap reward cap (unsigned).
- W_avg  input  32  average seed weight used in the linear penalty (unsigned).
- result  output  32  signed two's-complement chaining score.

Behaviour:
- Reset (reset=0): all pipeline registers and result clear to 0 immediately, independent of clk. They remain 0 while reset is low.
- First valid result appears LATENCY posedges after reset deasserts with stable inputs.
- Arithmetic, in 33-bit signed:
  - dr = riX − riY
  - dq = qiX − qiY
- Invalid pair: if dr ≤ 0 or dq ≤ 0, result = 32'h8000_0000 (INT32_MIN sentinel) and the remaining math is ignored.
- Otherwise:
  - dd = |dr − dq|
  - gap = min(dr, dq)
  - alpha = min(gap, W)
  - lin = floor(dd × W_avg / 100), using the full 64-bit unsigned product and exact integer division. Saturate lin to 2^31−1.
  - lg = floor(log2(dd)) >> 1 when dd ≥ 1; lg = 0 when dd = 0.
  - beta = (dd == 0) ? 0 : lin + lg, saturated to 2^31−1.
  - result = alpha − beta, computed signed and saturated to [−(2^31−1), 2^31−1]. This keeps the sentinel value unique.
- Pipeline stages, each registered on the posedge:
  - S1: dr, dq, invalid flag; W and W_avg carried forward.
  - S2: dd, alpha, floor(log2(dd)) via leading-one detector, 64-bit product dd×W_avg.
  - S3: divide-by-100 (constant reciprocal multiply or equivalent, bit-exact floor); beta formed.
  - S4: subtract and saturate; sentinel mux; drive result register.
- Throughput: one operand set per cycle. Inputs sampled at cycle k appear on result after posedge k+LATENCY. Changing inputs every cycle is legal and streams in order.
- Reset mid-stream flushes all in-flight operands; no partial results emerge after reset release.
- Result is held stable between updates (registered output, no combinational path from inputs).

Test Plan:
- Reset: hold reset=0 with arbitrary inputs -> result=0 throughout; release reset -> first nonzero result exactly 4 posedges later.
- Nominal: riX=100, riY=30, qiX=50, qiY=20, W=40, W_avg=40 (dr=70, dq=30, dd=40, alpha=30, beta=16+2=18) -> result=12, held constant for all later cycles.
- Zero diagonal drift: riX=200, riY=100, qiX=150, qiY=50, W=40, W_avg=40 -> dd=0, beta=0 -> result=40 (W caps alpha).
- Invalid order: riX=30, riY=100, qiX=50, qiY=20 -> result=32'h8000_0000. Also qiX=qiY (dq=0) -> sentinel.
- Large penalty, negative score: riX=1000, riY=0, qiX=10, qiY=0, W=50, W_avg=100 -> dd=990, beta=990+4=994 -> result=−984 (32'hFFFF_FC28).
- Streaming/reset mid-op: apply the nominal, zero-drift and invalid vectors on consecutive cycles -> results 12, 40, sentinel on consecutive cycles 4 posedges later. Pulse reset low for 1 cycle mid-stream -> result=0 immediately and no stale outputs afterwards.
